// File: rtl/deinterleaver_pkg.sv
// Shared constants, read-FSM state type and reference vectors for the 802.16 QPSK
// block deinterleaver (N_CBPS = 192, 16 columns x 12 rows).
package deinterleaver_pkg;

  localparam int N_CBPS = 192;
  localparam int N_COL  = 16;
  localparam int N_ROW  = N_CBPS / N_COL;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  // Reference block: interleaved input and expected FEC-domain output, both MSB first
  localparam logic [N_CBPS-1:0] TV_IN  = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
  localparam logic [N_CBPS-1:0] TV_OUT = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

endpackage

// File: rtl/deint_addr_gen.sv
// Write-side address generator: converts arrival position j into bank address
// k = N_COL*(j mod N_ROW) + floor(j/N_ROW) using row/column counters.
module deint_addr_gen #(
  parameter int N_CBPS = deinterleaver_pkg::N_CBPS,
  parameter int N_COL  = deinterleaver_pkg::N_COL,
  parameter int ADDR_W = $clog2(deinterleaver_pkg::N_CBPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_last
);
  import deinterleaver_pkg::*;

  localparam int ROWS  = N_CBPS / N_COL;
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(N_COL);

  logic [ROW_W-1:0] row_r;
  logic [COL_W-1:0] col_r;
  logic             row_end_s;
  logic             col_end_s;

  assign row_end_s = (row_r == ROW_W'(ROWS - 1));
  assign col_end_s = (col_r == COL_W'(N_COL - 1));

  // Row steps on every accepted bit; column steps when the row wraps. Gaps hold both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r <= '0;
      col_r <= '0;
    end else if (in_valid) begin
      if (row_end_s) begin
        row_r <= '0;
        col_r <= col_end_s ? '0 : col_r + 1'b1;
      end else begin
        row_r <= row_r + 1'b1;
      end
    end
  end

  assign wr_addr = ADDR_W'(N_COL) * ADDR_W'(row_r) + ADDR_W'(col_r);
  assign wr_last = in_valid & row_end_s & col_end_s;

endmodule

// File: rtl/deinterleaver_chk.sv
// Simulation checker: writing into a bank that is still FULL (and not being
// released this same cycle) would corrupt a block awaiting readout.
module deinterleaver_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       in_valid,
  input logic       wr_bank,
  input logic [1:0] full,
  input logic [1:0] clr
);

  property p_no_overrun;
    @(posedge clk) disable iff (!rst_n)
      in_valid |-> (!full[wr_bank] || clr[wr_bank]);
  endproperty

  a_no_overrun: assert property (p_no_overrun);

endmodule

// File: rtl/deinterleaver.sv
// Ping-pong block deinterleaver with serial in/out and 2-cycle block latency.
// Optional feature: define DEINTERLEAVER_BLKCNT_EN to add the 8-bit blk_cnt output.
module deinterleaver #(
  parameter int N_CBPS = deinterleaver_pkg::N_CBPS,
  parameter int N_COL  = deinterleaver_pkg::N_COL
) (
  input  logic       clk_100,
  input  logic       reset_N,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_sop
`ifdef DEINTERLEAVER_BLKCNT_EN
  ,
  output logic [7:0] blk_cnt
`endif
);
  import deinterleaver_pkg::*;

  localparam int                ADDR_W    = $clog2(N_CBPS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CBPS - 1);

  logic [ADDR_W-1:0] wr_addr_s;
  logic              wr_last_s;
  logic              wr_bank_r;
  logic [1:0]        full_r;
  logic [1:0]        set_s;
  logic [1:0]        clr_s;
  logic [N_CBPS-1:0] bank_r [2];
  rd_state_t         state_r;
  logic              rd_bank_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              rd_last_s;

  deint_addr_gen #(
    .N_CBPS (N_CBPS),
    .N_COL  (N_COL),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk_100),
    .rst_n    (reset_N),
    .in_valid (in_valid),
    .wr_addr  (wr_addr_s),
    .wr_last  (wr_last_s)
  );

  assign rd_last_s = (state_r == READ) && (rd_addr_r == LAST_ADDR);

  // Per-bank FULL set (block written) and clear (block fully read) requests
  always_comb begin
    set_s = 2'b00;
    clr_s = 2'b00;
    if (wr_last_s) begin
      set_s[wr_bank_r] = 1'b1;
    end else begin
      set_s = 2'b00;
    end
    if (rd_last_s) begin
      clr_s[rd_bank_r] = 1'b1;
    end else begin
      clr_s = 2'b00;
    end
  end

  // Bank storage; contents are don't-care after reset
  always_ff @(posedge clk_100) begin
    if (in_valid) begin
      bank_r[wr_bank_r][wr_addr_s] <= in_bit;
    end
  end

  // FULL flags and write-bank pointer
  always_ff @(posedge clk_100 or negedge reset_N) begin
    if (!reset_N) begin
      full_r    <= 2'b00;
      wr_bank_r <= 1'b0;
    end else begin
      full_r <= (full_r & ~clr_s) | set_s;
      if (wr_last_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
    end
  end

  // Read FSM with registered serial output; rd_bank follows the write alternation
  always_ff @(posedge clk_100 or negedge reset_N) begin
    if (!reset_N) begin
      state_r   <= IDLE;
      rd_bank_r <= 1'b0;
      rd_addr_r <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_sop   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid <= 1'b0;
          out_bit   <= 1'b0;
          out_sop   <= 1'b0;
          rd_addr_r <= '0;
          if (full_r[rd_bank_r]) begin
            state_r <= READ;
          end else if (full_r[~rd_bank_r]) begin
            rd_bank_r <= ~rd_bank_r;
            state_r   <= READ;
          end else begin
            state_r <= IDLE;
          end
        end
        READ: begin
          out_valid <= 1'b1;
          out_bit   <= bank_r[rd_bank_r][rd_addr_r];
          out_sop   <= (rd_addr_r == '0);
          if (rd_last_s) begin
            rd_addr_r <= '0;
            rd_bank_r <= ~rd_bank_r;
            state_r   <= full_r[~rd_bank_r] ? READ : IDLE;
          end else begin
            rd_addr_r <= rd_addr_r + 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          rd_addr_r <= '0;
          out_valid <= 1'b0;
          out_bit   <= 1'b0;
          out_sop   <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEINTERLEAVER_BLKCNT_EN
  logic eob_r;

  // Block counter steps the cycle after k=191 is presented
  always_ff @(posedge clk_100 or negedge reset_N) begin
    if (!reset_N) begin
      eob_r   <= 1'b0;
      blk_cnt <= 8'd0;
    end else begin
      eob_r <= rd_last_s;
      if (eob_r) begin
        blk_cnt <= blk_cnt + 8'd1;
      end
    end
  end
`endif

  deinterleaver_chk u_chk (
    .clk      (clk_100),
    .rst_n    (reset_N),
    .in_valid (in_valid),
    .wr_bank  (wr_bank_r),
    .full     (full_r),
    .clr      (clr_s)
  );

endmodule

// File: tb/tb_deinterleaver.sv
// Directed bench for deinterleaver: table of single-block vectors plus
// back-to-back, reset and (with DEINTERLEAVER_BLKCNT_EN) block-counter sequences.
`timescale 1ns/1ps
module tb_deinterleaver;

  localparam logic [191:0] VEC_IN  = 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E;
  localparam logic [191:0] VEC_OUT = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

  typedef struct {
    logic [191:0] din;
    logic [191:0] dout;
    bit           gapped;
  } vec_t;

  vec_t tbl [5];

  logic clk_100  = 1'b0;
  logic reset_N  = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit   = 1'b0;
  logic out_valid;
  logic out_bit;
  logic out_sop;
`ifdef DEINTERLEAVER_BLKCNT_EN
  logic [7:0] blk_cnt;
`endif

  deinterleaver dut (
    .clk_100   (clk_100),
    .reset_N   (reset_N),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_sop   (out_sop)
`ifdef DEINTERLEAVER_BLKCNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  always #5 clk_100 = ~clk_100;

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  // Output monitor: collects bits, SOP positions, valid runs and idle-state violations
  logic out_q [$];
  int   sop_q [$];
  int   runs      = 0;
  int   rise_cyc  = 0;
  int   idle_bad  = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk_100) begin
    if (out_valid === 1'b1) begin
      if (prev_valid !== 1'b1) begin
        runs = runs + 1;
        if (runs == 1) rise_cyc = cyc;
      end
      if (out_sop === 1'b1) sop_q.push_back(out_q.size());
      out_q.push_back(out_bit);
    end else if (out_bit !== 1'b0 || out_sop !== 1'b0) begin
      idle_bad = idle_bad + 1;
    end
    prev_valid = out_valid;
  end

  int passed = 0;
  int total  = 0;
  int last_edge = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clear_mon();
    out_q.delete();
    sop_q.delete();
    runs     = 0;
    idle_bad = 0;
  endtask

  function automatic logic [191:0] block_at(input int base);
    logic [191:0] v;
    for (int i = 0; i < 192; i++) begin
      v[191-i] = (base + i < out_q.size()) ? out_q[base + i] : 1'bx;
    end
    return v;
  endfunction

  task automatic send_block(input logic [191:0] v, input bit gapped, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      in_valid = 1'b1;
      in_bit   = v[191-i];
      @(posedge clk_100); #1;
      last_edge = cyc;
      if (gapped) begin
        in_valid = 1'b0;
        in_bit   = 1'b0;
        @(posedge clk_100); #1;
      end
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    for (int t = 0; t < 3000; t++) begin
      if (out_q.size() >= n && out_valid !== 1'b1) break;
      @(posedge clk_100); #1;
    end
  endtask

  function automatic int sop_at(input int idx);
    return (idx < sop_q.size()) ? sop_q[idx] : -1;
  endfunction

  initial begin
    tbl[0] = '{VEC_IN, VEC_OUT, 1'b0};
    tbl[1] = '{VEC_IN, VEC_OUT, 1'b1};
    tbl[2] = '{192'h4008_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000,
               192'h4000_8000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000, 1'b0};
    tbl[3] = '{192'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0801,
               192'h0001_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001, 1'b1};
    tbl[4] = '{{192{1'b1}}, {192{1'b1}}, 1'b0};

    // Reset state
    reset_N = 1'b0;
    repeat (3) @(posedge clk_100);
    #1;
    chk("reset out_valid", out_valid, 192'd0);
    chk("reset out_bit", out_bit, 192'd0);
    chk("reset out_sop", out_sop, 192'd0);
    reset_N = 1'b1;
    @(posedge clk_100); #1;

    // Single-block table
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      send_block(tbl[i].din, tbl[i].gapped, 192);
      wait_drain(192);
      chk($sformatf("v%0d count", i), out_q.size(), 192'd192);
      chk($sformatf("v%0d data", i), block_at(0), tbl[i].dout);
      chk($sformatf("v%0d contiguous", i), runs, 192'd1);
      chk($sformatf("v%0d sop count", i), sop_q.size(), 192'd1);
      chk($sformatf("v%0d sop pos", i), sop_at(0), 192'd0);
      chk($sformatf("v%0d idle outputs", i), idle_bad, 192'd0);
      if (!tbl[i].gapped) chk($sformatf("v%0d latency", i), rise_cyc - last_edge, 192'd2);
      repeat (4) @(posedge clk_100);
      #1;
    end

    // Three blocks back-to-back
    clear_mon();
    for (int b = 0; b < 3; b++) send_block(VEC_IN, 1'b0, 192);
    wait_drain(576);
    chk("b2b count", out_q.size(), 192'd576);
    chk("b2b contiguous", runs, 192'd1);
    chk("b2b sop count", sop_q.size(), 192'd3);
    chk("b2b sop0", sop_at(0), 192'd0);
    chk("b2b sop1", sop_at(1), 192'd192);
    chk("b2b sop2", sop_at(2), 192'd384);
    for (int b = 0; b < 3; b++) chk($sformatf("b2b data%0d", b), block_at(192 * b), VEC_OUT);
    chk("b2b idle outputs", idle_bad, 192'd0);

    // Reset after 100 input bits discards the partial block
    clear_mon();
    send_block(VEC_IN, 1'b0, 100);
    reset_N = 1'b0;
    repeat (2) @(posedge clk_100);
    #1;
    chk("midblk rst out_valid", out_valid, 192'd0);
    reset_N = 1'b1;
    @(posedge clk_100); #1;
    send_block(VEC_IN, 1'b0, 192);
    wait_drain(192);
    repeat (5) @(posedge clk_100);
    #1;
    chk("midblk count", out_q.size(), 192'd192);
    chk("midblk data", block_at(0), VEC_OUT);
    chk("midblk sop count", sop_q.size(), 192'd1);

    // Reset during readout aborts the block being read
    clear_mon();
    send_block(VEC_IN, 1'b0, 192);
    for (int t = 0; t < 500 && out_q.size() < 50; t++) begin
      @(posedge clk_100); #1;
    end
    chk("midread reached", (out_q.size() >= 50), 192'd1);
    reset_N = 1'b0;
    #2;
    chk("midread rst out_valid", out_valid, 192'd0);
    chk("midread rst out_bit", out_bit, 192'd0);
    chk("midread rst out_sop", out_sop, 192'd0);
    @(posedge clk_100); #1;
    reset_N = 1'b1;
    clear_mon();
    repeat (10) @(posedge clk_100);
    #1;
    chk("midread no resume", out_q.size(), 192'd0);
    send_block(tbl[2].din, 1'b0, 192);
    wait_drain(192);
    chk("midread next data", block_at(0), tbl[2].dout);
    chk("midread next count", out_q.size(), 192'd192);

`ifdef DEINTERLEAVER_BLKCNT_EN
    // 257 blocks wrap the 8-bit block counter to 1
    reset_N = 1'b0;
    repeat (2) @(posedge clk_100);
    #1;
    reset_N = 1'b1;
    @(posedge clk_100); #1;
    clear_mon();
    chk("blkcnt reset", blk_cnt, 192'd0);
    for (int b = 0; b < 257; b++) send_block(VEC_IN, 1'b0, 192);
    wait_drain(257 * 192);
    repeat (3) @(posedge clk_100);
    #1;
    chk("blkcnt count", out_q.size(), 192'd49344);
    chk("blkcnt wrap", blk_cnt, 192'd1);
    chk("blkcnt last data", block_at(256 * 192), VEC_OUT);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/deinterleaver.md
DEINTERLEAVER -- requirements
Module: deinterleaver

Interface
REQ-001 The block SHALL have parameter N_CBPS, default 192, meaning coded bits per block.
REQ-002 The block SHALL have parameter N_COL, default 16, meaning interleaver columns d; rows N_ROW = N_CBPS/N_COL = 12.
REQ-003 The block SHALL have port clk_100  input  1  meaning 100 MHz clock; all logic on rising edge.
REQ-004 The block SHALL have port reset_N  input  1  meaning asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  meaning in_bit is valid this cycle.
REQ-006 The block SHALL have port in_bit  input  1  meaning interleaved serial bit, block position j = 0..191 in arrival order.
REQ-007 The block SHALL have port out_valid  output  1  meaning out_bit is valid this cycle.
REQ-008 The block SHALL have port out_bit  output  1  meaning deinterleaved serial bit, position k = 0..191.
REQ-009 The block SHALL have port out_sop  output  1  meaning one-cycle pulse with k = 0 of each output block.

Function
REQ-010 Input position j SHALL be written to bank address k = N_COL*(j mod N_ROW) + floor(j/N_ROW), the inverse of the first WiMAX permutation; the second permutation is identity for QPSK (s=1).
REQ-011 Write addressing SHALL use a row counter (0..11) and a column counter (0..15); both advance only on in_valid=1; gaps SHALL hold them.
REQ-012 Storage SHALL be two 192-bit banks (ping-pong), each with a FULL flag; writes alternate banks per block, starting with bank 0.
REQ-013 On the 192nd accepted bit, the write bank's FULL flag SHALL set and writing SHALL switch to the other bank on the next in_valid.
REQ-014 Read FSM states SHALL be IDLE and READ; IDLE->READ when any bank is FULL; READ emits addresses 0..191 in order, one per cycle, no gaps.
REQ-015 Latency: out_valid SHALL rise with k=0 exactly 2 cycles after the edge sampling the block's final input bit (registered output).
REQ-016 At read address 191 the bank's FULL flag SHALL clear; if the other bank is FULL, READ SHALL continue with its k=0 on the next cycle (back-to-back blocks, out_valid stays high); otherwise -> IDLE.
REQ-017 A write to a bank and the clearing of its FULL flag in the same cycle SHALL both take effect (clear wins over nothing; write data valid).
REQ-018 in_valid on a bank still FULL (input faster than 1 bit/cycle sustained is impossible) SHALL be treated as a design error; an assertion SHALL flag it in simulation.
REQ-019 out_sop SHALL be high only in the cycle out_bit carries k=0; out_bit SHALL be 0 when out_valid=0.

Reset
REQ-020 While reset_N=0: out_valid=0, out_bit=0, out_sop=0, FSM=IDLE, counters=0, both FULL flags=0, write bank=0; bank contents need not reset.
REQ-021 Reset asserted mid-block SHALL discard partial input and any block being read; after release the next in_valid bit is j=0.

Configuration
REQ-022 With macro DEINTERLEAVER_BLKCNT_EN defined, the block SHALL add output blk_cnt (8 bits), reset 0, incrementing the cycle after each k=191 emission, wrapping 255->0.
REQ-023 Without DEINTERLEAVER_BLKCNT_EN, blk_cnt and its counter SHALL not exist.

Structure
REQ-024 The shared package SHALL hold N_CBPS/N_COL/N_ROW constants, the read-FSM state enum, and the deinterleaver test vectors (interleaved input and expected FEC-domain output).
REQ-025 One sub-module deint_addr_gen SHALL produce the write address and end-of-block strobe from in_valid.

Verification
REQ-026 Single block: 192'h4B047DFA42F2A5D5F61C021A5851E9A309A24FD58086BD1E sent MSB first, in_valid continuous -> 192 out bits MSB first equal 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA, checked with the 192-bit self-check task; out_sop once.
REQ-027 Latency: same block -> first out_valid exactly 2 cycles after last input edge.
REQ-028 Back-to-back: same vector 3 times continuous -> 576 contiguous out_valid cycles, 3 out_sop pulses 192 cycles apart, each block correct.
REQ-029 Gapped input: in_valid toggled 1,0 every cycle -> output identical to REQ-026, emitted contiguously.
REQ-030 Reset mid-block: reset_N low after 100 bits, then full vector -> no output from partial block, one correct block after.
REQ-031 With DEINTERLEAVER_BLKCNT_EN: 257 blocks -> blk_cnt reads 1 after final block (wrap observed).
